// File: rtl/bp_nonsynth_io_responder.sv
// Uncached I/O command terminator for testbenches.
//   Services uc_rd / uc_wr commands against a small dword-addressed store and
//   returns exactly one response per accepted command, in acceptance order.
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   io_cmd_i / _v_i          BedRock mem command (header + data), valid
//   io_cmd_ready_and_o       high while the response FIFO has a free entry
//   io_resp_o / _v_o         head-of-FIFO BedRock mem response, valid
//   io_resp_yumi_i           consumer takes the head response
//   err_o / err_addr_o       sticky error flag, address of the first bad command

package bp_nonsynth_io_responder_pkg;

  localparam int unsigned paddr_width_gp   = 40;
  localparam int unsigned lce_id_width_gp  = 4;
  localparam int unsigned lce_assoc_gp     = 8;
  localparam int unsigned way_id_width_gp  = $clog2(lce_assoc_gp);
  localparam int unsigned dword_width_gp   = 64;
  // The I/O link never moves more than a dword, so the data field is one dword.
  localparam int unsigned mem_data_width_gp = dword_width_gp;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bedrock_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
    logic [way_id_width_gp-1:0] way_id;
    logic                       uncached;
  } bedrock_mem_payload_s;

  typedef struct packed {
    bedrock_mem_type_e          msg_type;
    logic [3:0]                 subop;
    logic [paddr_width_gp-1:0]  addr;
    bedrock_msg_size_e          size;
    bedrock_mem_payload_s       payload;
  } bedrock_mem_header_s;

  typedef struct packed {
    bedrock_mem_header_s           header;
    logic [mem_data_width_gp-1:0]  data;
  } bedrock_mem_msg_s;

  localparam int unsigned mem_msg_width_gp = $bits(bedrock_mem_msg_s);

endpackage

module bp_nonsynth_io_responder
  import bp_nonsynth_io_responder_pkg::*;
#(
  parameter int unsigned                els_p       = 64,
  parameter logic [paddr_width_gp-1:0]  base_addr_p = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [mem_msg_width_gp-1:0]   io_cmd_i,
  input  logic                          io_cmd_v_i,
  output logic                          io_cmd_ready_and_o,
  output logic [mem_msg_width_gp-1:0]   io_resp_o,
  output logic                          io_resp_v_o,
  input  logic                          io_resp_yumi_i,
  output logic                          err_o,
  output logic [paddr_width_gp-1:0]     err_addr_o
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam logic [paddr_width_gp-1:0] span_lp = paddr_width_gp'(els_p * 8);

  bedrock_mem_msg_s            cmd;
  bedrock_mem_msg_s            resp;
  logic [paddr_width_gp-1:0]   rel_addr;
  logic [idx_width_lp-1:0]     idx;
  logic [2:0]                  off;
  logic [3:0]                  nbytes;
  logic [2:0]                  align_mask;
  logic                        legal;
  logic                        is_rd;
  logic                        is_wr;
  logic [7:0]                  byte_mask;
  logic [63:0]                 wdata;
  logic [63:0]                 rdata;
  logic [63:0]                 rmask;
  logic                        push;
  logic                        pop;
  logic                        wr_en;

  logic [63:0]                 store [els_p];
  bedrock_mem_msg_s            fifo_mem [2];
  logic                        wr_ptr;
  logic                        rd_ptr;
  logic [1:0]                  count;

  assign cmd = io_cmd_i;

  // Ready depends only on the registered occupancy.
  assign io_cmd_ready_and_o = (count < 2'd2);
  assign io_resp_v_o        = (count != 2'd0);
  assign io_resp_o          = fifo_mem[rd_ptr];

  assign push  = io_cmd_v_i & io_cmd_ready_and_o;
  assign pop   = io_resp_yumi_i & io_resp_v_o;
  assign wr_en = push & legal & is_wr;

  // Command decode, legality and response formation.
  always_comb begin
    rel_addr   = cmd.header.addr - base_addr_p;
    idx        = rel_addr[3 +: idx_width_lp];
    off        = rel_addr[2:0];
    nbytes     = 4'd1 << cmd.header.size[1:0];
    align_mask = 3'(nbytes - 4'd1);
    is_rd      = (cmd.header.msg_type == e_bedrock_mem_uc_rd);
    is_wr      = (cmd.header.msg_type == e_bedrock_mem_uc_wr);
    legal      = (is_rd | is_wr)
               & (cmd.header.size <= e_bedrock_msg_size_8)
               & (rel_addr < span_lp)
               & ((off & align_mask) == 3'd0);
    byte_mask  = 8'((9'd1 << nbytes) - 9'd1) << off;
    wdata      = cmd.data << {off, 3'b000};
    rdata      = store[idx] >> {off, 3'b000};
    // Keeps only the low n bytes of the shifted dword.
    rmask      = ~64'd0 >> (7'd64 - {nbytes, 3'b000});
    resp.header = cmd.header;
    resp.data   = (legal & is_rd) ? (rdata & rmask) : '0;
  end

  // Backing store: byte-masked writes, cleared on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(els_p); i++) store[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_mask[b]) store[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Two-entry response FIFO.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= resp;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Sticky error; address latched only by the first offending command.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (push & ~legal) begin
      err_o <= 1'b1;
      if (!err_o) err_addr_o <= cmd.header.addr;
    end
  end

  // The consumer may only take a response that is actually presented.
  yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) io_resp_yumi_i |-> io_resp_v_o);

endmodule

// File: doc/bp_nonsynth_io_responder.md
# bp_nonsynth_io_responder

Non-synthesizable BedRock memory-interface responder that terminates uncached I/O commands (`e_bedrock_mem_uc_rd` / `e_bedrock_mem_uc_wr`) against a small dword-addressed backing store and returns one response per command. It sits at the far end of the I/O command link, opposite an NBF loader or any other uncached initiator, in testbenches. Every accepted command produces exactly one response, so initiator credit counters always drain.

## Interface
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p`, `lce_assoc_p`, `dword_width_gp`.
- `els_p`, 64: backing-store depth in 64-bit dwords; power of two.
- `base_addr_p`, `'0`: byte address of dword 0; must be `els_p*8`-aligned.
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset. **One clock; reset is asynchronous and active-low.**
- `io_cmd_i`  in  `cce_mem_msg_width_lp`  BedRock mem command (header + data).
- `io_cmd_v_i`  in  1  command valid.
- `io_cmd_ready_and_o`  out  1  ready; transfer when `v & ready_and`.
- `io_resp_o`  out  `cce_mem_msg_width_lp`  BedRock mem response.
- `io_resp_v_o`  out  1  response valid.
- `io_resp_yumi_i`  in  1  consumer takes the head response; only legal when `io_resp_v_o`.
- `err_o`  out  1  sticky error flag.
- `err_addr_o`  out  `paddr_width_p`  address of the first erroring command.

## Operation
- Accept: on `io_cmd_v_i & io_cmd_ready_and_o`, decode the header and perform the access in that same cycle; push the response into a 2-entry response FIFO.
- Index: `idx = (addr - base_addr_p) >> 3`, offset `off = addr[2:0]`; size bytes `n = 1 << size` (sizes 1/2/4/8 only).
- Legal: `msg_type` ∈ {uc_rd, uc_wr}, `addr - base_addr_p < els_p*8`, `addr % n == 0`.
- uc_wr (legal): write bytes `off .. off+n-1` of `store[idx]` with bytes `0..n-1` of `io_cmd.data`; other bytes unchanged. Response data = 0.
- uc_rd (legal): response data bits `[8n-1:0]` = `store[idx] >> (8*off)` truncated to n bytes; all higher bits zero.
- Illegal: no store update, response data = 0, `err_o` set; `err_addr_o` captured only on the first error (while `err_o` = 0).
- Response header: exact copy of the command header (`msg_type`, `subop`, `addr`, `size`, `payload` including `lce_id`).
- Responses leave strictly in acceptance order.

## Timing
- Reset (async assert, sync deassert handled upstream): FIFO empty, `io_resp_v_o`=0, `io_cmd_ready_and_o`=1, `err_o`=0, `err_addr_o`=0, all store dwords = 0.
- Latency: command accepted in cycle T → response valid at T+1 (FIFO is registered; no combinational cmd→resp path).
- `io_cmd_ready_and_o` = FIFO count < 2; it depends only on registered count, not on same-cycle `io_resp_yumi_i`.
- Full sustained throughput: 1 cmd/cycle when the consumer yumis every cycle (count oscillates ≤1).
- Simultaneous push and pop with count = 1: count stays 1; with count = 2: no push (ready low), pop → count 1.
- Read-after-write: a uc_rd accepted the cycle after a uc_wr to the same dword sees the new data.
- Reset asserted mid-operation: FIFO contents and store cleared immediately; in-flight responses are lost.
- Yumi while `io_resp_v_o` = 0: illegal; flagged by a non-synth assertion.

## Test plan
- Post-reset: release `reset_n_i` → `io_cmd_ready_and_o`=1, `io_resp_v_o`=0, uc_rd 8B at `base_addr_p` returns data 0 at T+1.
- Write/read 8B: uc_wr addr `base+0x10` data `0x1122334455667788`, then uc_rd 8B same addr → response data `0x1122334455667788`, header `lce_id` echoed.
- Subword merge: uc_wr 1B addr `base+0x13` data `0xAB` onto that dword → uc_rd 8B returns `0x11223344AB667788`; uc_rd 2B addr `base+0x12` returns `0x0000_0000_0000_AB66`.
- Backpressure: hold `io_resp_yumi_i`=0, issue 3 back-to-back cmds → 2 accepted, ready drops after second; release yumi → third accepted, responses arrive in order.
- Errors: uc_wr 4B at `base+0x2` (misaligned) → response data 0, store unchanged, `err_o`=1, `err_addr_o`=`base+0x2`; later out-of-range uc_rd at `base+els_p*8` → still responded, `err_addr_o` unchanged.
- Async reset mid-burst: assert `reset_n_i` low between clock edges with 2 responses queued → `io_resp_v_o` drops immediately, store reads back 0 after release.
